// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side logic.
//   state_t : arbiter FSM encoding (IDLE=0, BURST=1)
//   clog2   : ceiling log2, used to size the id, beat and timeout counters
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector.
//   req    : request vector, one bit per consumer
//   rr_ptr : index where the search starts (highest priority)
//   winner : first set request at or above rr_ptr, wrapping modulo NUM_REQ
//   any    : at least one request is set (winner is meaningless otherwise)
module rr_pick
    import fifo_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [clog2(NUM_REQ)-1:0] winner,
    output logic                      any
);

    localparam int unsigned ID_W = clog2(NUM_REQ);

    logic            found;
    logic [31:0]     pos;
    logic [ID_W-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(rr_ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = ID_W'(pos);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing the async FIFO read port among NUM_REQ
// consumers in the rclk domain. A grant lasts for up to BURST_LEN words,
// ends early when the owner drops its request, and is released after
// TIMEOUT consecutive cycles of the owner waiting on an empty FIFO.
//   rclk, r_rst_n : read clock, synchronous active-low reset
//   req           : per-consumer request (level), doubles as ready
//   empty, rdata  : FIFO empty flag and read data (data valid after r_en)
//   r_en          : FIFO read enable, combinational from state/empty/req
//   gnt           : registered one-hot grant
//   out_valid     : out_data carries a word for consumer out_id
//   out_data      : rdata passthrough
//   out_id        : registered owner of the returned word
//   busy          : FSM is in BURST
module fifo_read_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                      rclk,
    input  logic                      r_rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic                      empty,
    input  logic [DATA_WIDTH-1:0]     rdata,
    output logic                      r_en,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [clog2(NUM_REQ)-1:0] out_id,
    output logic                      busy
);

    localparam int ID_W   = clog2(NUM_REQ);
    localparam int BEAT_W = clog2(BURST_LEN + 1);
    localparam int TO_W   = clog2(TIMEOUT + 1);

    localparam logic [BEAT_W-1:0]  BEAT_MAX  = BEAT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]    ID_LAST   = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

    state_t            state;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   owner_next;
    logic [BEAT_W-1:0] beat_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              any_req;
    logic              owner_req;
    logic              stall;
    logic              last_beat;
    logic              timed_out;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req   (req),
        .rr_ptr(rr_ptr),
        .winner(winner),
        .any   (any_req)
    );

    // Exit decisions look at the value the counters are about to take, so
    // the grant drops on the same edge that completes the last beat or the
    // TIMEOUT-th empty cycle.
    always_comb begin
        owner_req  = req[owner];
        r_en       = (state == BURST) && !empty && owner_req && (beat_cnt < BEAT_MAX);
        stall      = (state == BURST) && empty && owner_req;
        last_beat  = r_en && (beat_cnt == BEAT_LAST);
        timed_out  = stall && (to_cnt >= TO_LAST);
        owner_next = (owner == ID_LAST) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge rclk) begin
        if (!r_rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            to_cnt    <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
        end else begin
            out_valid <= r_en;
            out_id    <= owner;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= winner;
                        gnt      <= GNT_ONE << winner;
                        beat_cnt <= '0;
                        to_cnt   <= '0;
                        state    <= BURST;
                    end else begin
                        gnt <= '0;
                    end
                end
                BURST: begin
                    if (r_en) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        to_cnt   <= '0;
                    end else if (stall && to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    if (last_beat || !owner_req || timed_out) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        rr_ptr <= owner_next;
                    end
                end
            endcase
        end
    end

    assign busy     = (state == BURST);
    assign out_data = rdata;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter with a small FIFO model driving
// empty/rdata. Inputs change and outputs are sampled on the falling edge.
module tb_fifo_read_arbiter;

    logic       rclk = 1'b0;
    logic       r_rst_n;
    logic [3:0] req;
    logic       empty;
    logic [7:0] rdata = 8'h00;
    logic       r_en;
    logic [3:0] gnt;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_id;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:63];
    logic [5:0] wr_ptr = 6'd0;
    logic [5:0] rd_ptr = 6'd0;

    always #5 rclk = ~rclk;

    assign empty = (wr_ptr == rd_ptr);

    always @(posedge rclk) begin
        if (r_en) begin
            rdata  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 6'd1;
        end
    end

    fifo_read_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(8),
        .BURST_LEN (4),
        .TIMEOUT   (8)
    ) dut (
        .rclk     (rclk),
        .r_rst_n  (r_rst_n),
        .req      (req),
        .empty    (empty),
        .rdata    (rdata),
        .r_en     (r_en),
        .gnt      (gnt),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_id   (out_id),
        .busy     (busy)
    );

    task automatic tick;
        @(negedge rclk);
    endtask

    task automatic apply_reset;
        r_rst_n = 1'b0;
        req     = 4'b0000;
        repeat (2) tick;
        r_rst_n = 1'b1;
    endtask

    // Flush the FIFO model and fill it with n consecutive words from base.
    task automatic load(input logic [7:0] base, input int n);
        wr_ptr = rd_ptr;
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = base + 8'(i);
            wr_ptr      = wr_ptr + 6'd1;
        end
    endtask

    task automatic test_reset;
        r_rst_n = 1'b0;
        req     = 4'b1111;
        load(8'h00, 8);
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt c%0d: got %b want 0000", c, gnt); end
            checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL rst_ren c%0d: got %b want 0", c, r_en); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ovalid c%0d: got %b want 0", c, out_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy c%0d: got %b want 0", c, busy); end
            checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_outid c%0d: got %0d want 0", c, out_id); end
        end
        r_rst_n = 1'b1;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt: got %b want 0001", gnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_first_busy: got %b want 1", busy); end
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL rst_first_ren: got %b want 1", r_en); end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_full_burst;
        logic [3:0] eg [10] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
        logic       er [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       ev [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] ed [10] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15, 8'h16, 8'h17};
        apply_reset;
        load(8'h10, 8);
        req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            tick;
            checks++; if (gnt !== eg[c]) begin errors++; $display("FAIL burst_gnt c%0d: got %b want %b", c + 1, gnt, eg[c]); end
            checks++; if (r_en !== er[c]) begin errors++; $display("FAIL burst_ren c%0d: got %b want %b", c + 1, r_en, er[c]); end
            checks++; if (out_valid !== ev[c]) begin errors++; $display("FAIL burst_ovalid c%0d: got %b want %b", c + 1, out_valid, ev[c]); end
            if (ev[c]) begin
                checks++; if (out_data !== ed[c]) begin errors++; $display("FAIL burst_data c%0d: got %h want %h", c + 1, out_data, ed[c]); end
                checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL burst_id c%0d: got %0d want 1", c + 1, out_id); end
            end
        end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        int         w;
        apply_reset;
        load(8'h00, 32);
        req = 4'b1111;
        w   = 0;
        for (int c = 1; c <= 24; c++) begin
            tick;
            exp_g = ((c - 1) % 5 == 4) ? 4'b0000 : (4'b0001 << (((c - 1) / 5) % 4));
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, exp_g); end
            checks++; if (r_en !== (exp_g != 4'b0000)) begin errors++; $display("FAIL rr_ren c%0d: got %b want %b", c, r_en, exp_g != 4'b0000); end
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== 8'(w)) begin errors++; $display("FAIL rr_data c%0d: got %h want %h", c, out_data, 8'(w)); end
                checks++; if (out_id !== 2'((w / 4) % 4)) begin errors++; $display("FAIL rr_id c%0d: got %0d want %0d", c, out_id, (w / 4) % 4); end
                w++;
            end
        end
        checks++; if (w !== 19) begin errors++; $display("FAIL rr_words: got %0d want 19", w); end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_timeout;
        logic [3:0] exp_g;
        logic       exp_r;
        apply_reset;
        load(8'hA0, 2);
        req = 4'b0011;
        for (int c = 1; c <= 12; c++) begin
            tick;
            exp_g = (c <= 10) ? 4'b0001 : ((c == 11) ? 4'b0000 : 4'b0010);
            exp_r = (c <= 2);
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL to_gnt c%0d: got %b want %b", c, gnt, exp_g); end
            checks++; if (r_en !== exp_r) begin errors++; $display("FAIL to_ren c%0d: got %b want %b", c, r_en, exp_r); end
            checks++; if (busy !== (exp_g != 4'b0000)) begin errors++; $display("FAIL to_busy c%0d: got %b want %b", c, busy, exp_g != 4'b0000); end
            checks++; if (r_en === 1'b1 && empty === 1'b1) begin errors++; $display("FAIL to_ren_empty c%0d: got r_en=1 with empty=1 want r_en=0", c); end
            if (c == 2 || c == 3) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL to_ovalid c%0d: got %b want 1", c, out_valid); end
                checks++; if (out_data !== ((c == 2) ? 8'hA0 : 8'hA1)) begin errors++; $display("FAIL to_data c%0d: got %h want %h", c, out_data, (c == 2) ? 8'hA0 : 8'hA1); end
                checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL to_id c%0d: got %0d want 0", c, out_id); end
            end
        end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_early_release;
        apply_reset;
        load(8'h30, 8);
        req = 4'b0101;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL er_gnt0: got %b want 0001", gnt); end
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL er_ren1: got %b want 1", r_en); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h30) begin errors++; $display("FAIL er_word1: got v=%b d=%h want v=1 d=30", out_valid, out_data); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h31) begin errors++; $display("FAIL er_word2: got v=%b d=%h want v=1 d=31", out_valid, out_data); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL er_word2_id: got %0d want 0", out_id); end
        req = 4'b0100;
        #1;
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL er_ren_drop: got %b want 0", r_en); end
        tick;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL er_gap_gnt: got %b want 0000", gnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL er_gap_ovalid: got %b want 0", out_valid); end
        tick;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL er_next_gnt: got %b want 0100", gnt); end
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL er_next_ren: got %b want 1", r_en); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h32 || out_id !== 2'd2) begin errors++; $display("FAIL er_next_word: got v=%b d=%h id=%0d want v=1 d=32 id=2", out_valid, out_data, out_id); end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_reset_mid_burst;
        apply_reset;
        load(8'h50, 8);
        req = 4'b0100;
        tick;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt: got %b want 0100", gnt); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h50) begin errors++; $display("FAIL mid_word1: got v=%b d=%h want v=1 d=50", out_valid, out_data); end
        tick;
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL mid_ren3: got %b want 1", r_en); end
        r_rst_n = 1'b0;
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ovalid: got %b want 0", out_valid); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt_rst: got %b want 0000", gnt); end
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL mid_ren_rst: got %b want 0", r_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_rst: got %b want 0", busy); end
        req     = 4'b1111;
        r_rst_n = 1'b1;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_rrptr: got %b want 0001", gnt); end
        req = 4'b0000;
        tick;
    endtask

    initial begin
        test_reset;
        test_full_burst;
        test_round_robin;
        test_timeout;
        test_early_release;
        test_reset_mid_burst;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Round-robin arbiter that shares the read port of the asynchronous FIFO's read side among NUM_REQ consumers in the rclk domain. It grants the port to one consumer at a time for bursts of up to BURST_LEN words. It drives the FIFO read enable from the FIFO empty flag and the consumer requests, and tags each returned word with the owning consumer's index. A timeout releases a grant held on an empty FIFO, so no consumer can stall the others.

## Interface
- NUM_REQ, 4: number of consumers, 2..8
- DATA_WIDTH, 8: FIFO word width
- BURST_LEN, 4: maximum words per grant, 1..16
- TIMEOUT, 8: consecutive empty cycles in BURST before the grant is released, 1..255

Ports:
- rclk  in  1  read-domain clock; all logic on the rising edge
- r_rst_n  in  1  synchronous reset, active-low
- req  in  NUM_REQ  per-consumer read request, level; also acts as ready
- empty  in  1  FIFO empty flag (rclk domain)
- rdata  in  DATA_WIDTH  FIFO read data, valid in the cycle after r_en
- r_en  out  1  FIFO read enable, one word per high cycle
- gnt  out  NUM_REQ  one-hot grant, registered
- out_valid  out  1  out_data holds a word for consumer out_id
- out_data  out  DATA_WIDTH  rdata passthrough
- out_id  out  clog2(NUM_REQ)  owner of the current out_data word, registered
- busy  out  1  high while in BURST

## Operation
- States: IDLE and BURST.
- Registers: owner, beat_cnt (0..BURST_LEN), to_cnt (0..TIMEOUT), rr_ptr, out_valid, out_id.
- **IDLE:**
  - If req is nonzero, pick the winner: the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Next cycle: owner = winner, gnt = onehot(winner), beat_cnt = 0, to_cnt = 0, state = BURST.
  - If req is zero, stay in IDLE with gnt = 0.
- **BURST:**
  - r_en = !empty && req[owner] && (beat_cnt < BURST_LEN), combinational.
  - beat_cnt increments on every r_en cycle.
  - to_cnt increments on each cycle with empty=1 and req[owner]=1, and clears when r_en=1.
  - Exit to IDLE on the next edge when any of these holds:
    - beat_cnt reaches BURST_LEN after the last r_en;
    - req[owner]=0;
    - to_cnt reaches TIMEOUT.
  - On exit: gnt = 0 and rr_ptr = (owner+1) mod NUM_REQ.
- **Read return:**
  - out_valid <= r_en and out_id <= owner, registered.
  - out_data = rdata in the out_valid cycle.
  - A word read on the final beat is delivered even though gnt has already dropped.
- **Never:**
  - r_en asserted while empty=1;
  - r_en asserted in IDLE;
  - more than one gnt bit set.

## Timing
- Reset (r_rst_n=0 at an edge), all outputs:
  - state IDLE;
  - gnt = 0, r_en = 0, out_valid = 0, out_id = 0, busy = 0;
  - rr_ptr = 0, beat_cnt = 0, to_cnt = 0.
- Reset mid-burst:
  - the pending out_valid is dropped;
  - r_en is low from the reset edge onward, since it is gated by state.
- Latency:
  - req rises at edge N, gnt and busy are seen after edge N+1, first r_en in that cycle if !empty;
  - r_en in cycle k gives out_valid in cycle k+1.
- Back-to-back bursts: one IDLE cycle with gnt=0 separates consecutive grants.
- Full BURST_LEN burst with FIFO non-empty: BURST_LEN consecutive r_en cycles, exit on the edge after the last one.
- Simultaneous req drop and empty: exit takes priority over the timeout count.
- beat_cnt is clog2(BURST_LEN+1) bits wide.
- to_cnt saturates at TIMEOUT.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Structure
- Shared package fifo_pkg holds:
  - state encoding: IDLE=0, BURST=1;
  - the clog2 helper for the id, beat_cnt and to_cnt widths.
- One sub-module, rr_pick: combinational round-robin priority selector (req, rr_ptr -> winner index, any).
- The FSM and counters stay in the top module.

## Test plan
- **Reset:** hold r_rst_n=0 with req=4'b1111 and empty=0 -> gnt=0, r_en=0, out_valid=0 throughout; after release, the first grant goes to consumer 0.
- **Full burst:** req=4'b0010, FIFO preloaded with 0x10..0x17, BURST_LEN=4 ->
  - gnt=4'b0010;
  - four consecutive r_en;
  - out_data 0x10..0x13 with out_id=1;
  - one IDLE cycle, then re-grant to consumer 1 reading 0x14..0x17.
- **Round-robin:** req=4'b1111 held, FIFO never empty -> grant order 0,1,2,3,0, each with exactly 4 beats.
- **Empty stall and timeout:** req=4'b0011, FIFO holds 2 words, TIMEOUT=8 ->
  - consumer 0 reads 2 words;
  - r_en=0 for 8 empty cycles;
  - grant releases and moves to consumer 1;
  - r_en never asserts while empty=1.
- **Early release:** drop req[owner] after 2 beats -> no r_en in that cycle, the second word is still delivered with the correct out_id, next grant follows rotation.
- **Reset mid-burst:** assert r_rst_n=0 in the cycle after the second r_en -> out_valid=0 at the next edge, gnt=0, rr_ptr=0.
